// File: rtl/battleship_player_board.sv
// battleship_player_board
//   Per-player board datapath. Holds this player's ship map, its own attack
//   map and the hits it has received. It answers the game controller's load
//   strobes and reports attack-entry legality (ok) and ships remaining (liv).
// Ports
//   clk, clr       : clock (rising edge) and asynchronous active-high reset
//   sw             : player switches, one per cell (placement / attack entry)
//   opp_atk        : opponent's registered attack map
//   ld1            : SETUP: load ships from sw; PLAY: absorb opponent shots
//   ld2            : PLAY: commit sw as the new attack map when ok
//   ok, liv        : combinational status back to the controller
//   ships/atk/hits : registered maps
//   hit_cnt        : popcount of hits
//   shot_cnt       : committed attacks, saturating at 255
//   hit_flash      : high for FLASH_CYCLES cycles after a new hit lands
//   phase          : 0=SETUP 1=PLAY 2=DONE
module battleship_player_board #(
  parameter int N_CELLS      = 16,
  parameter int FLASH_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [N_CELLS-1:0]           sw,
  input  logic [N_CELLS-1:0]           opp_atk,
  input  logic                         ld1,
  input  logic                         ld2,
  output logic                         ok,
  output logic                         liv,
  output logic [N_CELLS-1:0]           ships,
  output logic [N_CELLS-1:0]           atk,
  output logic [N_CELLS-1:0]           hits,
  output logic [$clog2(N_CELLS+1)-1:0] hit_cnt,
  output logic [7:0]                   shot_cnt,
  output logic                         hit_flash,
  output logic [1:0]                   phase
);

  localparam int HW = $clog2(N_CELLS + 1);
  localparam int FW = $clog2(FLASH_CYCLES + 1);

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    PLAY  = 2'd1,
    DONE  = 2'd2
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [N_CELLS-1:0] ships_q, ships_d;
  logic [N_CELLS-1:0] atk_q, atk_d;
  logic [N_CELLS-1:0] hits_q, hits_d;
  logic [HW-1:0]      hit_cnt_q, hit_cnt_d;
  logic [7:0]         shot_cnt_q, shot_cnt_d;
  logic [FW-1:0]      flash_cnt_q, flash_cnt_d;
  logic               ld1_q, ld1_d;

  logic [N_CELLS-1:0] new_hits;
  logic [N_CELLS-1:0] fresh;
  logic               one_new;
  logic               flash_load;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase_q     <= SETUP;
      ships_q     <= '0;
      atk_q       <= '0;
      hits_q      <= '0;
      hit_cnt_q   <= '0;
      shot_cnt_q  <= '0;
      flash_cnt_q <= '0;
      ld1_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      ships_q     <= ships_d;
      atk_q       <= atk_d;
      hits_q      <= hits_d;
      hit_cnt_q   <= hit_cnt_d;
      shot_cnt_q  <= shot_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      ld1_q       <= ld1_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    ships_d     = ships_q;
    atk_d       = atk_q;
    hits_d      = hits_q;
    shot_cnt_d  = shot_cnt_q;
    ld1_d       = ld1;
    flash_load  = 1'b0;

    new_hits = ships_q & opp_atk & ~hits_q;
    fresh    = sw & ~atk_q;
    // Exactly one bit set: nonzero and clearing its lowest set bit leaves zero.
    one_new  = (fresh != '0) && ((fresh & (fresh - N_CELLS'(1))) == '0);

    ok  = (phase_q == PLAY) && one_new && ((atk_q & ~sw) == '0);
    liv = (phase_q == SETUP) || ((ships_q & ~hits_q) != '0);

    unique case (phase_q)
      SETUP: begin
        if (ld1) ships_d = sw;
        if (ld1_q && !ld1 && (ships_q != '0)) phase_d = PLAY;
      end
      PLAY: begin
        if (ld2 && ok) begin
          atk_d = sw;
          if (shot_cnt_q != 8'hFF) shot_cnt_d = shot_cnt_q + 8'd1;
        end
        if (ld1) begin
          hits_d = hits_q | new_hits;
          if (new_hits != '0) flash_load = 1'b1;
          if ((ships_q & ~hits_d) == '0) phase_d = DONE;
        end
      end
      default: ;
    endcase

    hit_cnt_d = '0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      hit_cnt_d = hit_cnt_d + HW'(hits_d[i]);
    end

    // A new hit restarts the flash even if one is already running.
    if (flash_load)
      flash_cnt_d = FW'(FLASH_CYCLES);
    else if (flash_cnt_q != '0)
      flash_cnt_d = flash_cnt_q - FW'(1);
    else
      flash_cnt_d = flash_cnt_q;
  end

  assign ships     = ships_q;
  assign atk       = atk_q;
  assign hits      = hits_q;
  assign hit_cnt   = hit_cnt_q;
  assign shot_cnt  = shot_cnt_q;
  assign hit_flash = (flash_cnt_q != '0);
  assign phase     = phase_q;

endmodule

// File: tb/tb_battleship_player_board.sv
module tb_battleship_player_board;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] sw = '0, opp_atk = '0;
  logic        ld1 = 1'b0, ld2 = 1'b0;
  logic        ok, liv, hit_flash;
  logic [15:0] ships, atk, hits;
  logic [4:0]  hit_cnt;
  logic [7:0]  shot_cnt;
  logic [1:0]  phase;

  // Wide instance: enough cells for more than 255 legal commits.
  logic [255:0] sw_w = '0, opp_w = '0;
  logic         ld1_w = 1'b0, ld2_w = 1'b0;
  logic         ok_w, liv_w, flash_w;
  logic [255:0] ships_w, atk_w, hits_w;
  logic [8:0]   hit_cnt_w;
  logic [7:0]   shot_w;
  logic [1:0]   phase_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  battleship_player_board #(.N_CELLS(16), .FLASH_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .sw(sw), .opp_atk(opp_atk), .ld1(ld1), .ld2(ld2),
    .ok(ok), .liv(liv), .ships(ships), .atk(atk), .hits(hits),
    .hit_cnt(hit_cnt), .shot_cnt(shot_cnt), .hit_flash(hit_flash), .phase(phase)
  );

  battleship_player_board #(.N_CELLS(256), .FLASH_CYCLES(4)) dut_w (
    .clk(clk), .clr(clr), .sw(sw_w), .opp_atk(opp_w), .ld1(ld1_w), .ld2(ld2_w),
    .ok(ok_w), .liv(liv_w), .ships(ships_w), .atk(atk_w), .hits(hits_w),
    .hit_cnt(hit_cnt_w), .shot_cnt(shot_w), .hit_flash(flash_w), .phase(phase_w)
  );

  typedef struct {
    logic [15:0] sw;
    logic [15:0] opp;
    logic        ld1;
    logic        ld2;
    logic        ok;     // before the edge
    logic        liv;    // before the edge
    logic [15:0] ships;  // after the edge
    logic [15:0] atk;
    logic [15:0] hits;
    logic [4:0]  hc;
    logic [7:0]  sc;
    logic [1:0]  ph;
    logic        fl;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " phase"},    32'(phase), 32'd0);
    chk({tag, " ships"},    32'(ships), 32'h0);
    chk({tag, " atk"},      32'(atk), 32'h0);
    chk({tag, " hits"},     32'(hits), 32'h0);
    chk({tag, " hit_cnt"},  32'(hit_cnt), 32'd0);
    chk({tag, " shot_cnt"}, 32'(shot_cnt), 32'd0);
    chk({tag, " flash"},    32'(hit_flash), 32'd0);
    chk({tag, " ok"},       32'(ok), 32'd0);
    chk({tag, " liv"},      32'(liv), 32'd1);
  endtask

  task automatic step(input logic [15:0] s, input logic [15:0] o, input logic l1, input logic l2);
    @(negedge clk);
    sw = s; opp_atk = o; ld1 = l1; ld2 = l2;
    @(posedge clk);
    #1;
  endtask

  logic [255:0] acc;

  initial begin
    //        sw       opp      l1 l2 ok liv ships    atk      hits     hc sc ph fl
    vecs[0]  = '{16'h000F, 16'h0000, 1, 0, 0, 1, 16'h000F, 16'h0000, 16'h0000, 0, 0, 0, 0};
    vecs[1]  = '{16'h000F, 16'h0000, 1, 0, 0, 1, 16'h000F, 16'h0000, 16'h0000, 0, 0, 0, 0};
    vecs[2]  = '{16'h000F, 16'h0000, 1, 0, 0, 1, 16'h000F, 16'h0000, 16'h0000, 0, 0, 0, 0};
    vecs[3]  = '{16'h000F, 16'h0000, 0, 0, 0, 1, 16'h000F, 16'h0000, 16'h0000, 0, 0, 1, 0};
    vecs[4]  = '{16'h0001, 16'h0000, 0, 0, 1, 1, 16'h000F, 16'h0000, 16'h0000, 0, 0, 1, 0};
    vecs[5]  = '{16'h0003, 16'h0000, 0, 0, 0, 1, 16'h000F, 16'h0000, 16'h0000, 0, 0, 1, 0};
    vecs[6]  = '{16'h0001, 16'h0000, 0, 1, 1, 1, 16'h000F, 16'h0001, 16'h0000, 0, 1, 1, 0};
    vecs[7]  = '{16'h0001, 16'h0000, 0, 1, 0, 1, 16'h000F, 16'h0001, 16'h0000, 0, 1, 1, 0};
    vecs[8]  = '{16'h0002, 16'h0000, 0, 0, 0, 1, 16'h000F, 16'h0001, 16'h0000, 0, 1, 1, 0};
    vecs[9]  = '{16'h0002, 16'h0000, 0, 1, 0, 1, 16'h000F, 16'h0001, 16'h0000, 0, 1, 1, 0};
    vecs[10] = '{16'h0003, 16'h0005, 1, 1, 1, 1, 16'h000F, 16'h0003, 16'h0005, 2, 2, 1, 1};
    vecs[11] = '{16'h0003, 16'h0005, 0, 0, 0, 1, 16'h000F, 16'h0003, 16'h0005, 2, 2, 1, 1};
    vecs[12] = '{16'h0003, 16'h0005, 1, 0, 0, 1, 16'h000F, 16'h0003, 16'h0005, 2, 2, 1, 1};
    vecs[13] = '{16'h0003, 16'h0005, 1, 0, 0, 1, 16'h000F, 16'h0003, 16'h0005, 2, 2, 1, 1};
    vecs[14] = '{16'h0003, 16'h0000, 0, 0, 0, 1, 16'h000F, 16'h0003, 16'h0005, 2, 2, 1, 0};
    vecs[15] = '{16'h0003, 16'h000F, 1, 0, 0, 1, 16'h000F, 16'h0003, 16'h000F, 4, 2, 2, 1};
    vecs[16] = '{16'h0007, 16'h000F, 0, 1, 0, 0, 16'h000F, 16'h0003, 16'h000F, 4, 2, 2, 1};
    vecs[17] = '{16'h00F0, 16'h00F0, 1, 0, 0, 0, 16'h000F, 16'h0003, 16'h000F, 4, 2, 2, 1};

    pulse_clr();
    #1;
    chk_reset("reset");

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      sw = vecs[i].sw; opp_atk = vecs[i].opp; ld1 = vecs[i].ld1; ld2 = vecs[i].ld2;
      #1;
      chk($sformatf("v%0d ok", i),  32'(ok),  32'(vecs[i].ok));
      chk($sformatf("v%0d liv", i), 32'(liv), 32'(vecs[i].liv));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ships", i),    32'(ships),     32'(vecs[i].ships));
      chk($sformatf("v%0d atk", i),      32'(atk),       32'(vecs[i].atk));
      chk($sformatf("v%0d hits", i),     32'(hits),      32'(vecs[i].hits));
      chk($sformatf("v%0d hit_cnt", i),  32'(hit_cnt),   32'(vecs[i].hc));
      chk($sformatf("v%0d shot_cnt", i), 32'(shot_cnt),  32'(vecs[i].sc));
      chk($sformatf("v%0d phase", i),    32'(phase),     32'(vecs[i].ph));
      chk($sformatf("v%0d flash", i),    32'(hit_flash), 32'(vecs[i].fl));
    end

    // DONE: flash keeps timing out (loaded at v15, 2 left after v17).
    step(16'h0000, 16'h0000, 0, 0);
    chk("done flash 1left", 32'(hit_flash), 32'd1);
    step(16'h0000, 16'h0000, 0, 0);
    chk("done flash expired", 32'(hit_flash), 32'd0);
    chk("done liv", 32'(liv), 32'd0);
    chk("done phase held", 32'(phase), 32'd2);

    // ld1 falling with empty ship map stays in SETUP.
    pulse_clr();
    step(16'h0000, 16'h0000, 1, 0);
    step(16'h0000, 16'h0000, 0, 0);
    step(16'h0000, 16'h0000, 0, 0);
    chk("empty setup phase", 32'(phase), 32'd0);
    chk("empty setup liv", 32'(liv), 32'd1);
    chk("empty setup ships", 32'(ships), 32'h0);

    // Shot counter saturation on the wide instance.
    @(negedge clk);
    sw_w = 256'd1; ld1_w = 1'b1;
    @(negedge clk);
    ld1_w = 1'b0;
    @(negedge clk);
    chk("wide phase play", 32'(phase_w), 32'd1);
    acc = '0;
    for (int k = 0; k < 256; k++) begin
      acc[k] = 1'b1;
      sw_w = acc; ld2_w = 1'b1;
      @(posedge clk);
      #1;
      if (k == 253) chk("wide shot 254", 32'(shot_w), 32'd254);
      if (k == 254) chk("wide shot 255", 32'(shot_w), 32'd255);
      @(negedge clk);
    end
    ld2_w = 1'b0;
    chk("wide shot saturated", 32'(shot_w), 32'd255);
    chk("wide atk all", 32'(atk_w == '1), 32'd1);

    // Asynchronous clear in the middle of PLAY with a flash running.
    pulse_clr();
    step(16'h000F, 16'h0000, 1, 0);
    step(16'h000F, 16'h0000, 0, 0);
    step(16'h0001, 16'h0000, 0, 1);
    step(16'h0001, 16'h0001, 1, 0);
    chk("pre-clr flash", 32'(hit_flash), 32'd1);
    chk("pre-clr shot", 32'(shot_cnt), 32'd1);
    @(negedge clk);
    ld1 = 1'b0; ld2 = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk_reset("midclr");
    chk("midclr wide shot", 32'(shot_w), 32'd0);
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
